// File: rtl/fetch_queue_ctrl.sv
// Prefetching FIFO controller over an external simple-dual-port RAM with
// one-cycle read latency, feeding a 2-entry output buffer for full-rate popping.
module fetch_queue_ctrl #(
    parameter int Word_Length = 8,
    parameter int W_DEPTH     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    input  logic [Word_Length-1:0]       push_data,
    output logic                         push_ready,
    output logic                         pop_valid,
    output logic [Word_Length-1:0]       pop_data,
    input  logic                         pop_ready,
    input  logic                         flush,
    output logic [$clog2(W_DEPTH)+1:0]   count,
    output logic                         mem_we,
    output logic [Word_Length-1:0]       mem_data_wr,
    output logic [$clog2(W_DEPTH)-1:0]   mem_addr_wr,
    output logic                         mem_re,
    output logic [$clog2(W_DEPTH)-1:0]   mem_addr_rd,
    input  logic [Word_Length-1:0]       mem_data_rd
);
    localparam int AW = $clog2(W_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = AW + 2;
    localparam logic [PW-1:0] DEPTH_P = PW'(W_DEPTH);

    logic [PW-1:0]          wr_ptr, rd_ptr, ram_count;
    logic [1:0]             ob_count;
    logic                   ob_hd, ob_tail;
    logic                   rd_pend;
    logic [Word_Length-1:0] ob_mem [2];
    logic                   push_fire, pop_fire;
    logic [2:0]             ob_occ;

    always_comb begin
        ram_count   = wr_ptr - rd_ptr;
        push_ready  = !rst && !flush && (ram_count < DEPTH_P);
        push_fire   = push_valid && push_ready;
        mem_we      = push_fire;
        mem_addr_wr = wr_ptr[AW-1:0];
        mem_data_wr = push_data;

        pop_valid   = !rst && !flush && (ob_count != 2'd0);
        pop_data    = ob_mem[ob_hd];
        pop_fire    = pop_valid && pop_ready;

        // Read only if the word (plus any in flight) still fits after this cycle's pop.
        ob_occ      = 3'(ob_count) + 3'(rd_pend);
        mem_re      = !rst && !flush && (ram_count != '0) &&
                      (ob_occ < (3'd2 + 3'(pop_fire)));
        mem_addr_rd = rd_ptr[AW-1:0];

        // With a full buffer and a pop, the tail aliases the departing head slot.
        ob_tail     = ob_hd ^ ob_count[0];
        count       = CW'(ram_count) + CW'(rd_pend) + CW'(ob_count);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ob_count <= '0;
            ob_hd    <= 1'b0;
            rd_pend  <= 1'b0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PW'(1);
            if (mem_re)    rd_ptr <= rd_ptr + PW'(1);
            rd_pend <= mem_re;
            if (rd_pend)   ob_mem[ob_tail] <= mem_data_rd;
            if (pop_fire)  ob_hd <= ~ob_hd;
            ob_count <= ob_count + 2'(rd_pend) - 2'(pop_fire);
        end
    end
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl: behavioural RAM, FIFO reference queue
// for popped data, and cycle-exact checks of handshake and memory-port timing.
module tb_fetch_queue_ctrl;
    logic       clk = 1'b0;
    logic       rst, push_valid, push_ready, pop_valid, pop_ready, flush;
    logic [7:0] push_data, pop_data, mem_data_wr, mem_data_rd;
    logic [5:0] count;
    logic       mem_we, mem_re;
    logic [3:0] mem_addr_wr, mem_addr_rd;

    logic [7:0] ram [16];
    logic [7:0] model_q [$];
    int checks = 0, failures = 0, pops = 0;

    fetch_queue_ctrl #(.Word_Length(8), .W_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
        .flush(flush), .count(count),
        .mem_we(mem_we), .mem_data_wr(mem_data_wr), .mem_addr_wr(mem_addr_wr),
        .mem_re(mem_re), .mem_addr_rd(mem_addr_rd), .mem_data_rd(mem_data_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr_wr] <= mem_data_wr;
        if (mem_re) mem_data_rd <= ram[mem_addr_rd];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference FIFO: every popped word must be the oldest accepted word.
    always @(negedge clk) begin
        if (rst || flush) begin
            model_q.delete();
        end else begin
            if (pop_valid && pop_ready) begin
                pops++;
                if (model_q.size() == 0) chk("pop_on_empty_model", 32'(pop_data), 32'hFFFF);
                else chk("pop_order", 32'(pop_data), 32'(model_q.pop_front()));
            end
            if (push_valid && push_ready) model_q.push_back(push_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        bit done = 0;
        pop_ready = 1'b1;
        push_valid = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (count == 0 && !pop_valid) begin
                done = 1;
                break;
            end
            tick();
        end
        if (done) tick();
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt, p0, drops, obbad;
        bit found;
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
        #1;
        tick();
        @(negedge clk);
        chk("rst_push_ready", 32'(push_ready), 0);
        chk("rst_pop_valid",  32'(pop_valid),  0);
        chk("rst_mem_we",     32'(mem_we),     0);
        chk("rst_mem_re",     32'(mem_re),     0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_push_ready", 32'(push_ready), 1);
        tick();

        // Single word latency
        push_valid = 1'b1; push_data = 8'hA5;
        @(negedge clk);
        chk("c0_mem_we", 32'(mem_we), 1);
        chk("c0_addr_wr", 32'(mem_addr_wr), 0);
        chk("c0_data_wr", 32'(mem_data_wr), 32'hA5);
        tick();
        push_valid = 1'b0;
        @(negedge clk);
        chk("c1_mem_re", 32'(mem_re), 1);
        chk("c1_addr_rd", 32'(mem_addr_rd), 0);
        chk("c1_count", 32'(count), 1);
        tick();
        @(negedge clk);
        chk("c2_pop_valid", 32'(pop_valid), 0);
        chk("c2_count", 32'(count), 1);
        tick();
        @(negedge clk);
        chk("c3_pop_valid", 32'(pop_valid), 1);
        chk("c3_pop_data", 32'(pop_data), 32'hA5);
        chk("c3_count", 32'(count), 1);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        @(negedge clk);
        chk("c4_count", 32'(count), 0);
        chk("c4_pop_valid", 32'(pop_valid), 0);
        tick();

        // Fill with consumer stalled
        nxt = 0;
        for (int c = 0; c < 30; c++) begin
            push_valid = (nxt < 20);
            push_data = 8'(nxt);
            @(negedge clk);
            if (push_valid && push_ready) nxt++;
            tick();
        end
        push_valid = 1'b0;
        @(negedge clk);
        chk("fill_accepted", 32'(nxt), 18);
        chk("fill_push_ready", 32'(push_ready), 0);
        chk("fill_count", 32'(count), 18);
        chk("fill_head", 32'(pop_data), 0);
        tick();
        p0 = pops;
        drain("fill_drain", 40);
        chk("fill_pops", 32'(pops - p0), 18);
        p0 = pops;
        for (int c = 0; c < 10 && nxt < 20; c++) begin
            push_valid = 1'b1;
            push_data = 8'(nxt);
            @(negedge clk);
            if (push_ready) nxt++;
            tick();
        end
        drain("fill_tail_drain", 20);
        chk("fill_tail_pops", 32'(pops - p0), 2);

        // Streaming with wrap-around
        pop_ready = 1'b1;
        p0 = pops; drops = 0;
        for (int k = 0; k < 40; k++) begin
            push_valid = 1'b1;
            push_data = 8'(8'h40 + k);
            @(negedge clk);
            if (!push_ready) drops++;
            tick();
        end
        chk("stream_drops", 32'(drops), 0);
        drain("stream_drain", 20);
        chk("stream_pops", 32'(pops - p0), 40);

        // Toggling backpressure
        p0 = pops; nxt = 0; obbad = 0;
        for (int c = 0; c < 100; c++) begin
            push_valid = (nxt < 20);
            push_data = 8'(8'h80 + nxt);
            pop_ready = c[0];
            @(negedge clk);
            if (push_valid && push_ready) nxt++;
            if (dut.ob_count > 2) obbad++;
            tick();
        end
        chk("bp_pushed", 32'(nxt), 20);
        chk("bp_ob_bound", 32'(obbad), 0);
        drain("bp_drain", 30);
        chk("bp_pops", 32'(pops - p0), 20);

        // Flush with a read in flight
        pop_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_valid = 1'b1;
            push_data = 8'(8'h50 + k);
            tick();
        end
        push_valid = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("fl_count5", 32'(count), 5);
        tick();
        pop_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_re) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("fl_saw_mem_re", 32'(found), 1);
        tick();
        flush = 1'b1; pop_ready = 1'b0;
        @(negedge clk);
        chk("fl_mem_re_gated", 32'(mem_re), 0);
        chk("fl_pop_valid_gated", 32'(pop_valid), 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_count0", 32'(count), 0);
        chk("fl_pop_valid0", 32'(pop_valid), 0);
        tick();
        p0 = pops;
        push_valid = 1'b1; push_data = 8'h77;
        tick();
        push_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("fl_77_valid", 32'(pop_valid), 1);
        chk("fl_77_data", 32'(pop_data), 32'h77);
        tick();
        drain("fl_drain", 10);
        chk("fl_pops", 32'(pops - p0), 1);

        // Reset with data queued
        pop_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push_valid = 1'b1;
            push_data = 8'(8'h60 + k);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mr_push_ready", 32'(push_ready), 0);
        chk("mr_pop_valid", 32'(pop_valid), 0);
        chk("mr_mem_we", 32'(mem_we), 0);
        chk("mr_mem_re", 32'(mem_re), 0);
        tick();
        rst = 1'b0; push_valid = 1'b0;
        @(negedge clk);
        chk("mr_count", 32'(count), 0);
        chk("mr_push_ready_after", 32'(push_ready), 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
